// File: rtl/fp_add_sequencer_if.sv
// fp_add_sequencer_if: element stream, float adder and sum-out signals of the add sequencer
interface fp_add_sequencer_if;
    logic        InValid;
    logic        InReady;
    logic [31:0] InData;
    logic        InLast;
    logic [31:0] AddOp1;
    logic [31:0] AddOp2;
    logic        AddInputValid;
    logic [31:0] AddResult;
    logic        AddResultValid;
    logic        AddInputInvalid;
    logic        AddOutputInvalid;
    logic [31:0] SumOut;
    logic        SumValid;
    logic        SumInvalid;
    logic        Timeout;
    logic        Busy;

    modport master (
        input  InValid, InData, InLast, AddResult, AddResultValid, AddInputInvalid, AddOutputInvalid,
        output InReady, AddOp1, AddOp2, AddInputValid, SumOut, SumValid, SumInvalid, Timeout, Busy
    );

    modport slave (
        output InValid, InData, InLast, AddResult, AddResultValid, AddInputInvalid, AddOutputInvalid,
        input  InReady, AddOp1, AddOp2, AddInputValid, SumOut, SumValid, SumInvalid, Timeout, Busy
    );
endinterface

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: sums a stream of floats through an external adder, one add at a time.
module fp_add_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic Clock,
    input logic Reset,
    fp_add_sequencer_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} stateT;

    stateT state, nextState;
    logic first, last, sticky, sumInvalidReg, accept, expired;
    logic [31:0] acc, op1, op2, sumReg;
    logic [TW-1:0] timer;

    assign accept  = bus.InValid && state == IDLE;
    assign expired = state == WAIT && !bus.AddResultValid && timer == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge Clock)
        state <= Reset ? IDLE : nextState;

    always_comb begin
        nextState = state;
        bus.InReady = state == IDLE;
        bus.AddInputValid = state == ISSUE;
        bus.SumValid = state == DONE;
        bus.Busy = state != IDLE;
        bus.Timeout = expired;
        bus.AddOp1 = op1;
        bus.AddOp2 = op2;
        bus.SumOut = state == DONE ? acc : sumReg;
        bus.SumInvalid = state == DONE ? sticky : sumInvalidReg;
        nextState = state == IDLE  ? (accept ? (first ? (bus.InLast ? DONE : IDLE) : ISSUE) : IDLE)
                  : state == ISSUE ? WAIT
                  : state == WAIT  ? (bus.AddResultValid ? (last ? DONE : IDLE) : expired ? DONE : WAIT)
                  : IDLE;
    end

    // Result in the WAIT cycle where the timer expires wins over the abort.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            first <= 1'b1;
            last <= 1'b0;
            sticky <= 1'b0;
            sumInvalidReg <= 1'b0;
            acc <= '0;
            op1 <= '0;
            op2 <= '0;
            sumReg <= '0;
            timer <= '0;
        end else begin
            if (accept && first) begin
                acc <= bus.InData;
                first <= 1'b0;
            end
            if (accept && !first) begin
                op1 <= acc;
                op2 <= bus.InData;
                last <= bus.InLast;
            end
            if (state == ISSUE) begin
                sticky <= sticky | bus.AddInputInvalid;
                timer <= '0;
            end
            if (state == WAIT) begin
                timer <= timer + 1'b1;
                if (bus.AddResultValid) begin
                    acc <= bus.AddResult;
                    sticky <= sticky | bus.AddOutputInvalid;
                end else if (expired)
                    sticky <= 1'b1;
            end
            if (state == DONE) begin
                sumReg <= acc;
                sumInvalidReg <= sticky;
                sticky <= 1'b0;
                first <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: directed streams against a table-driven float adder and a stream-level sum model.
module tb_fp_add_sequencer;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    fp_add_sequencer_if bus();
    fp_add_sequencer #(.TIMEOUT_CYCLES(8)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    int nCmp = 0, nErr = 0, cyc = 0;
    int lat = 3, startCyc = 0, acceptCyc = 0;
    bit hang = 0, running = 0, addBusy = 0;
    logic rv = 1'b1;
    logic [31:0] res = '0, pendRes = '0;

    function automatic bit special(input logic [31:0] x);
        return x[30:23] == 8'hFF;
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if ((special(a) && a[22:0] != 0) || (special(b) && b[22:0] != 0)) return 32'h7FC00000;
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h40400000, 32'h40400000}: return 32'h40C00000;
            {32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            {32'h3F800000, 32'h40400000}: return 32'h40800000;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    // Adder: level valid that drops after a start pulse and rises lat cycles after it.
    assign bus.AddResult = res;
    assign bus.AddResultValid = rv;
    assign bus.AddOutputInvalid = rv && special(res);
    assign bus.AddInputInvalid = special(bus.AddOp1) || special(bus.AddOp2);

    always @(posedge Clock) begin
        cyc <= cyc + 1;
        if (bus.AddInputValid) begin
            startCyc <= cyc;
            pendRes <= fadd(bus.AddOp1, bus.AddOp2);
            rv <= 1'b0;
            addBusy <= 1'b1;
        end else if (addBusy && !hang && cyc + 1 - startCyc >= lat) begin
            rv <= 1'b1;
            res <= pendRes;
            addBusy <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [32:0] expQ[$];
    logic [31:0] stim[8];
    int modelAdds = 0, modelSums = 0, modelTo = 0;

    task automatic model(input int n);
        logic [31:0] a;
        logic inv;
        a = stim[0];
        inv = 1'b0;
        for (int i = 1; i < n; i++) begin
            modelAdds++;
            if (hang) begin
                inv = 1'b1;
                modelTo++;
                break;
            end
            inv = inv | special(a) | special(stim[i]);
            a = fadd(a, stim[i]);
            inv = inv | special(a);
        end
        expQ.push_back({inv, a});
        modelSums++;
    endtask

    int nAdds = 0, nTo = 0, sumCount = 0, lastIssue = 0, lastSumCyc = 0, toCyc = 0;
    logic [31:0] lastSum, op1Rec, op2Rec;
    logic lastInv;

    always @(negedge Clock) begin
        if (Reset) begin
            op1Rec = '0;
            op2Rec = '0;
        end else if (running) begin
            chk("ready_vs_busy", bus.InReady, !bus.Busy);
            if (bus.AddInputValid) begin
                nAdds++;
                lastIssue = cyc;
                op1Rec = bus.AddOp1;
                op2Rec = bus.AddOp2;
                chk("ready_in_issue", bus.InReady, 0);
            end else if (bus.Busy) begin
                chk("op1_stable", bus.AddOp1, op1Rec);
                chk("op2_stable", bus.AddOp2, op2Rec);
            end
            if (bus.Timeout) begin
                nTo++;
                toCyc = cyc;
                chk("timeout_latency", cyc - lastIssue, 8);
            end
            if (bus.SumValid) begin
                sumCount++;
                lastSumCyc = cyc;
                lastSum = bus.SumOut;
                lastInv = bus.SumInvalid;
                if (expQ.size() == 0) begin
                    nCmp++;
                    nErr++;
                    $display("FAIL unexpected_sum: got %h expected none", bus.SumOut);
                end else begin
                    logic [32:0] e;
                    e = expQ.pop_front();
                    chk("sum_out", bus.SumOut, e[31:0]);
                    chk("sum_invalid", bus.SumInvalid, e[32]);
                end
            end
        end
    end

    task automatic sendElem(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        bus.InValid = 1'b1;
        bus.InData = d;
        bus.InLast = l;
        @(negedge Clock);
        while (!bus.InReady && n < 100) begin
            @(negedge Clock);
            n++;
        end
        if (!bus.InReady) begin
            nCmp++;
            nErr++;
            $display("FAIL accept_wait: got InReady=0 expected 1 within 100 cycles");
        end
        acceptCyc = cyc;
        @(posedge Clock);
        #1;
    endtask

    task automatic sendStream(input int n, input bit keep);
        model(n);
        for (int i = 0; i < n; i++) sendElem(stim[i], i == n - 1);
        if (!keep) bus.InValid = 1'b0;
    endtask

    task automatic waitSums();
        int n;
        n = 0;
        while (sumCount < modelSums && n < 200) begin
            @(posedge Clock);
            #1;
            n++;
        end
        chk("sum_count_wait", sumCount, modelSums);
    endtask

    initial begin
        int addsBefore;
        bus.InValid = 1'b0;
        bus.InData = '0;
        bus.InLast = 1'b0;
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        chk("rst_in_ready", bus.InReady, 1);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_sum_out", bus.SumOut, 0);
        chk("rst_sum_valid", bus.SumValid, 0);
        chk("rst_sum_invalid", bus.SumInvalid, 0);
        chk("rst_timeout", bus.Timeout, 0);
        chk("rst_add_valid", bus.AddInputValid, 0);
        chk("rst_op1", bus.AddOp1, 0);
        chk("rst_op2", bus.AddOp2, 0);
        chk("pin_fadd_1_2", fadd(32'h3F800000, 32'h40000000), 32'h40400000);
        chk("pin_fadd_3_3", fadd(32'h40400000, 32'h40400000), 32'h40C00000);
        chk("pin_fadd_nan", fadd(32'h3F800000, 32'h7FC00000), 32'h7FC00000);
        running = 1;
        @(posedge Clock);
        #1;

        stim[0] = 32'h3F800000; stim[1] = 32'h40000000; stim[2] = 32'h40400000;
        sendStream(3, 0);
        waitSums();
        chk("s1_sum", lastSum, 32'h40C00000);
        chk("s1_invalid", lastInv, 0);

        stim[0] = 32'h40490FDB;
        addsBefore = nAdds;
        sendStream(1, 0);
        waitSums();
        chk("single_latency", lastSumCyc - acceptCyc, 1);
        chk("single_no_add", nAdds, addsBefore);
        chk("single_sum", lastSum, 32'h40490FDB);

        stim[0] = 32'h3F800000; stim[1] = 32'h7FC00000;
        sendStream(2, 0);
        waitSums();
        chk("nan_invalid", lastInv, 1);
        stim[0] = 32'h3F800000; stim[1] = 32'h40000000;
        sendStream(2, 0);
        waitSums();
        chk("clean_after_nan_invalid", lastInv, 0);
        chk("clean_after_nan_sum", lastSum, 32'h40400000);

        lat = 8;
        stim[0] = 32'h40000000; stim[1] = 32'h40000000;
        sendStream(2, 0);
        waitSums();
        chk("late_result_no_timeout", nTo, 0);
        chk("late_result_sum", lastSum, 32'h40800000);
        lat = 2;
        stim[0] = 32'h3F800000; stim[1] = 32'h40400000;
        sendStream(2, 0);
        waitSums();
        chk("fast_sum", lastSum, 32'h40800000);

        hang = 1;
        stim[0] = 32'h3F800000; stim[1] = 32'h40000000;
        sendStream(2, 0);
        waitSums();
        hang = 0;
        chk("timeout_count", nTo, 1);
        chk("timeout_to_sum", lastSumCyc - toCyc, 1);
        chk("timeout_invalid", lastInv, 1);
        chk("timeout_sum", lastSum, 32'h3F800000);
        stim[0] = 32'h40490FDB;
        sendStream(1, 0);
        waitSums();
        chk("clean_after_timeout", lastInv, 0);

        lat = 5;
        sendElem(32'h3F800000, 0);
        sendElem(32'h40000000, 0);
        bus.InValid = 1'b0;
        modelAdds++;
        @(posedge Clock);
        #1 Reset = 1'b1;
        @(posedge Clock);
        #1 Reset = 1'b0;
        repeat (6) @(posedge Clock);
        @(negedge Clock);
        chk("abandon_sum_out", bus.SumOut, 0);
        chk("abandon_busy", bus.Busy, 0);
        chk("abandon_sums", sumCount, modelSums);
        @(posedge Clock);
        #1;
        lat = 3;
        stim[0] = 32'h3F800000; stim[1] = 32'h3F800000;
        sendStream(2, 0);
        waitSums();
        chk("after_reset_sum", lastSum, 32'h40000000);

        addsBefore = nAdds;
        stim[0] = 32'h3F800000; stim[1] = 32'h40000000; stim[2] = 32'h40400000;
        sendStream(3, 1);
        stim[0] = 32'h3F800000; stim[1] = 32'h40400000;
        sendStream(2, 0);
        waitSums();
        chk("continuous_adds", nAdds - addsBefore, 3);
        chk("continuous_sum", lastSum, 32'h40800000);

        repeat (4) @(posedge Clock);
        #1;
        chk("total_adds", nAdds, modelAdds);
        chk("total_timeouts", nTo, modelTo);
        chk("total_sums", sumCount, modelSums);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 20000 cycles");
        $fatal(1, "watchdog");
    end
endmodule
